// File: rtl/divider_datapath.sv
// divider_datapath: shift-subtract datapath executing init/left/right/sub micro-ops for a WIDTH-bit unsigned divider
module divider_datapath #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             init,
  input  logic             left,
  input  logic             right,
  input  logic             sub,
  output logic             cnt_is_0,
  output logic             divisor_is_0,
  output logic             dvsr_less_than_dvnd,
  output logic             shifted_divisor_MSB,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  logic [WIDTH-1:0] rem, dvsr, quot;
  logic [CW-1:0]    cnt;
  logic             le, q_bit, do_right, do_left;
  // status flags and op qualification, all from pre-edge register values
  always_comb begin
    le                  = dvsr <= rem;
    q_bit               = sub & le;
    do_right            = right & ~left;
    do_left             = left & ~right & ~dvsr[WIDTH-1] & (cnt != CNT_MAX);
    cnt_is_0            = cnt == '0;
    divisor_is_0        = dvsr == '0;
    dvsr_less_than_dvnd = le;
    shifted_divisor_MSB = dvsr[WIDTH-1];
    quotient            = quot;
    remainder           = rem;
  end
  // working registers; init overrides every other op, subtract is gated so rem never underflows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem  <= '0;
      dvsr <= '0;
      quot <= '0;
      cnt  <= '0;
    end else if (init) begin
      rem  <= dividend;
      dvsr <= divisor;
      quot <= '0;
      cnt  <= '0;
    end else begin
      if (q_bit) rem <= rem - dvsr;
      if (do_right) begin
        dvsr <= dvsr >> 1;
        quot <= {quot[WIDTH-2:0], q_bit};
        cnt  <= (cnt == '0) ? '0 : cnt - 1'b1;
      end else if (do_left) begin
        dvsr <= dvsr << 1;
        cnt  <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_divider_datapath.sv
// tb_divider_datapath: directed and randomized checks of the divider datapath against a behavioural model
module tb_divider_datapath;
  logic       clk = 0, reset = 1;
  logic [7:0] dividend = 0, divisor = 0;
  logic       init = 0, left = 0, right = 0, sub = 0;
  logic       cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, shifted_divisor_MSB;
  logic [7:0] quotient, remainder;
  int tests = 0, failed = 0;
  int m_rem, m_dvsr, m_quot, m_cnt;

  divider_datapath #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
    .init(init), .left(left), .right(right), .sub(sub),
    .cnt_is_0(cnt_is_0), .divisor_is_0(divisor_is_0),
    .dvsr_less_than_dvnd(dvsr_less_than_dvnd), .shifted_divisor_MSB(shifted_divisor_MSB),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rem"}, 32'(remainder), 32'(m_rem));
    chk({tag, ".quot"}, 32'(quotient), 32'(m_quot));
    chk({tag, ".dvsr"}, 32'(dut.dvsr), 32'(m_dvsr));
    chk({tag, ".cnt"}, 32'(dut.cnt), 32'(m_cnt));
    chk({tag, ".cnt0"}, 32'(cnt_is_0), 32'(m_cnt == 0));
    chk({tag, ".div0"}, 32'(divisor_is_0), 32'(m_dvsr == 0));
    chk({tag, ".lt"}, 32'(dvsr_less_than_dvnd), 32'(m_dvsr <= m_rem));
    chk({tag, ".msb"}, 32'(shifted_divisor_MSB), 32'(m_dvsr >= 128));
  endtask

  task automatic model_reset();
    m_rem = 0; m_dvsr = 0; m_quot = 0; m_cnt = 0;
  endtask

  // one clock with the given ops; model follows the arithmetic meaning of each op
  task automatic step(input string tag, input bit i, input bit l, input bit r, input bit s,
                      input int a = 0, input int b = 0);
    bit fits, qb;
    int nd, nc, nq;
    dividend = 8'(a); divisor = 8'(b);
    init = i; left = l; right = r; sub = s;
    if (i) begin
      m_rem = a; m_dvsr = b; m_quot = 0; m_cnt = 0;
    end else begin
      fits = m_dvsr <= m_rem;
      qb = s && fits;
      nd = m_dvsr; nc = m_cnt; nq = m_quot;
      if (qb) m_rem = m_rem - m_dvsr;
      if (r && !l) begin
        nd = m_dvsr / 2;
        nq = (m_quot * 2 + int'(qb)) % 256;
        nc = (m_cnt > 0) ? m_cnt - 1 : 0;
      end else if (l && !r && m_dvsr < 128 && m_cnt < 7) begin
        nd = m_dvsr * 2;
        nc = m_cnt + 1;
      end
      m_dvsr = nd; m_cnt = nc; m_quot = nq;
    end
    @(posedge clk); #1;
    init = 0; left = 0; right = 0; sub = 0;
    check_all(tag);
  endtask

  task automatic divide(input string tag, input int a, input int b, input bit always_sub);
    int k;
    step({tag, ".init"}, 1, 0, 0, 0, a, b);
    k = 0;
    while (m_dvsr < 128 && k < 7) begin
      step({tag, ".left"}, 0, 1, 0, 0);
      k++;
    end
    for (int j = 0; j <= k; j++)
      step({tag, ".right"}, 0, 0, 1, always_sub ? 1'b1 : bit'(m_dvsr <= m_rem));
  endtask

  initial begin
    int a, b;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check_all("por");

    // asynchronous reset in the middle of a division
    step("t1.init", 1, 0, 0, 0, 200, 7);
    step("t1.l", 0, 1, 0, 0);
    step("t1.l", 0, 1, 0, 0);
    #2 reset = 1;
    #1 model_reset();
    check_all("t1.async");
    chk("t1.flags", {28'd0, cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, shifted_divisor_MSB}, 32'b1110);
    @(posedge clk); #1 reset = 0;

    divide("t2", 200, 7, 0);
    chk("t2.q", 32'(quotient), 28);
    chk("t2.r", 32'(remainder), 4);
    chk("t2.c0", 32'(cnt_is_0), 1);

    divide("t3", 255, 1, 0);
    chk("t3.q", 32'(quotient), 255);
    chk("t3.r", 32'(remainder), 0);

    divide("t4", 3, 9, 1);
    chk("t4.q", 32'(quotient), 0);
    chk("t4.r", 32'(remainder), 3);

    step("t5.init", 1, 0, 0, 0, 10, 0);
    chk("t5.div0", 32'(divisor_is_0), 1);
    repeat (9) step("t5.left", 0, 1, 0, 0);
    chk("t5.cnt", 32'(dut.cnt), 7);
    chk("t5.dvsr", 32'(dut.dvsr), 0);
    repeat (9) step("t5.right", 0, 0, 1, 0);
    chk("t5.cnt0", 32'(cnt_is_0), 1);

    step("t6.init", 1, 0, 0, 0, 200, 7);
    step("t6.l", 0, 1, 0, 0);
    step("t6.l", 0, 1, 0, 0);
    step("t6.lr", 0, 1, 1, 0);
    chk("t6.lr.dvsr", 32'(dut.dvsr), 28);
    chk("t6.lr.cnt", 32'(dut.cnt), 2);
    chk("t6.lr.quot", 32'(quotient), 0);
    step("t6.lrs", 0, 1, 1, 1);
    chk("t6.lrs.rem", 32'(remainder), 172);
    step("t6.il", 1, 1, 0, 0, 200, 7);
    chk("t6.il.dvsr", 32'(dut.dvsr), 7);
    chk("t6.il.cnt", 32'(dut.cnt), 0);

    for (int n = 0; n < 25; n++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      divide("rnd", a, b, 0);
      chk("rnd.q", 32'(quotient), 32'(a / b));
      chk("rnd.r", 32'(remainder), 32'(a % b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
